// File: rtl/vote_frame_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vote_pkg
// Brief    : Shared types and constants for the vote frame collector.
// Revision : 1.0 - initial release
// ============================================================================
package vote_pkg;

  // Bits per presented vote frame
  localparam int FRAME_W = 3;

  // Width of the inter-vote idle timer
  localparam int TIMER_W = 8;

  // Default inter-vote timeout, in idle cycles
  localparam int TIMEOUT_DEFAULT = 15;

  // Collector states; encoding 2'd3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vote_frame_collector_idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : idle_timer
// Brief    : Counts idle cycles between accepted votes and flags expiry on the
//            cycle where the count reaches TIMEOUT-1 while still running.
// Revision : 1.0 - initial release
// ============================================================================
module idle_timer
  import vote_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  // Expiry is qualified by run so an accepted vote always beats the timeout
  assign expired = run && (count == LIMIT);

  // Idle counter: cleared on a vote, outside COLLECT, or once it has expired
  always_ff @(posedge clk) begin
    if (rst || clr || expired) begin
      count <= '0;
    end else if (run) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vote_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : vote_frame_collector
// Brief    : Gathers three serial vote bits into a frame, presents it with en
//            until ack, discards stale partial frames and counts delivered
//            frames.
// Revision : 1.0 - initial release
// ============================================================================
module vote_frame_collector
  import vote_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vote_in,
  input  logic               vote_valid,
  output logic               vote_ready,
  output logic [FRAME_W-1:0] abc,
  output logic               en,
  input  logic               ack,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   frame_cnt
);

  state_t      state;
  // Only the two most recent votes need storing; the third arrives live
  logic [1:0]  sh;
  logic [1:0]  vote_cnt;
  logic        accept;
  logic        timer_run;
  logic        timer_expired;

  // Readiness depends on state alone so upstream never sees a valid->ready path
  assign vote_ready = (state != PRESENT);
  assign accept     = vote_valid && vote_ready;

  // Timer only advances while a partial frame is waiting for its next vote
  assign timer_run  = (state == COLLECT) && !accept;

  idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!timer_run),
    .run     (timer_run),
    .expired (timer_expired)
  );

  // Frame collection FSM with registered frame, enable, error and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sh          <= '0;
      vote_cnt    <= '0;
      abc         <= '0;
      en          <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sh       <= {sh[0], vote_in};
            vote_cnt <= 2'd1;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            sh <= {sh[0], vote_in};
            if (vote_cnt == 2'd2) begin
              abc      <= {sh, vote_in};
              en       <= 1'b1;
              vote_cnt <= 2'd0;
              state    <= PRESENT;
            end else begin
              vote_cnt <= 2'd2;
            end
          end else if (timer_expired) begin
            // Stale partial frame: drop it, keep the last presented abc
            sh          <= '0;
            vote_cnt    <= 2'd0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        PRESENT: begin
          if (ack) begin
            en        <= 1'b0;
            frame_cnt <= frame_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: begin
          sh       <= '0;
          vote_cnt <= 2'd0;
          en       <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vote_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_vote_frame_collector
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a queue-based reference model of the collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vote_frame_collector;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;
  // {en, abc, timeout_err, frame_cnt, vote_ready} after reset
  localparam logic [14:0] RESET_OUT = 15'b0_000_0_00000000_1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vote_in = 1'b0;
  logic       vote_valid = 1'b0;
  logic       ack = 1'b0;
  logic       vote_ready;
  logic [2:0] abc;
  logic       en;
  logic       timeout_err;
  logic [7:0] frame_cnt;
  logic [14:0] dut_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: votes held so far, idle cycles, presented frame
  bit         held[$];
  bit         m_present = 1'b0;
  logic [2:0] m_abc = 3'b000;
  bit         m_terr = 1'b0;
  int         m_idle = 0;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  vote_frame_collector #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vote_in     (vote_in),
    .vote_valid  (vote_valid),
    .vote_ready  (vote_ready),
    .abc         (abc),
    .en          (en),
    .ack         (ack),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt)
  );

  assign dut_out = {en, abc, timeout_err, frame_cnt, vote_ready};

  function automatic void model_step(bit r, bit v, bit vi, bit a);
    if (r) begin
      held.delete();
      m_present = 1'b0;
      m_abc     = 3'b000;
      m_terr    = 1'b0;
      m_idle    = 0;
      m_cnt     = 0;
      return;
    end
    m_terr = 1'b0;
    if (m_present) begin
      if (a) begin
        m_present = 1'b0;
        m_cnt     = (m_cnt + 1) % (1 << CNT_W);
      end
    end else if (v) begin
      held.push_back(vi);
      m_idle = 0;
      if (held.size() == 3) begin
        m_abc     = {held[0], held[1], held[2]};
        m_present = 1'b1;
        held.delete();
      end
    end else if (held.size() > 0) begin
      if (m_idle == TIMEOUT - 1) begin
        held.delete();
        m_idle = 0;
        m_terr = 1'b1;
      end else begin
        m_idle++;
      end
    end
  endfunction

  function automatic logic [14:0] model_out();
    return {m_present, m_abc, m_terr, 8'(m_cnt), ~m_present};
  endfunction

  task automatic tick(input bit r, input bit v, input bit vi, input bit a);
    @(negedge clk);
    rst        = r;
    vote_valid = v;
    vote_in    = vi;
    ack        = a;
    @(posedge clk);
    model_step(r, v, vi, a);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0);
    tick(1, 1, 1, 1);
    checks++;
    if (dut_out !== RESET_OUT) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", dut_out, RESET_OUT);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (dut_out !== model_out()) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", dut_out, model_out());
    end
  endtask

  task automatic test_basic_frame();
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    checks++;
    if ({en, abc, vote_ready} !== {1'b1, 3'b101, 1'b0}) begin
      errors++;
      $display("FAIL basic_present: got en=%b abc=%b ready=%b expected en=1 abc=101 ready=0",
               en, abc, vote_ready);
    end
    tick(0, 0, 0, 1);
    checks++;
    if ({en, frame_cnt} !== {1'b0, 8'd1}) begin
      errors++;
      $display("FAIL basic_ack: got en=%b cnt=%0d expected en=0 cnt=1", en, frame_cnt);
    end
  endtask

  task automatic test_timeout();
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      tick(0, 0, 1, 0);
      checks++;
      if (timeout_err !== (i == TIMEOUT) || dut_out !== model_out()) begin
        errors++;
        $display("FAIL timeout_idle%0d: got terr=%b out=%b expected terr=%b out=%b",
                 i, timeout_err, dut_out, (i == TIMEOUT), model_out());
      end
    end
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    checks++;
    if ({en, abc} !== {1'b1, 3'b011}) begin
      errors++;
      $display("FAIL timeout_next_frame: got en=%b abc=%b expected en=1 abc=011", en, abc);
    end
    tick(0, 0, 0, 1);
  endtask

  task automatic test_no_timeout();
    int terr_seen;
    terr_seen = 0;
    tick(0, 1, 1, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick(0, 0, 0, 0);
      terr_seen += int'(timeout_err);
    end
    tick(0, 1, 0, 0);
    terr_seen += int'(timeout_err);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick(0, 0, 0, 0);
      terr_seen += int'(timeout_err);
    end
    tick(0, 1, 0, 0);
    terr_seen += int'(timeout_err);
    checks++;
    if (terr_seen != 0 || {en, abc} !== {1'b1, 3'b100}) begin
      errors++;
      $display("FAIL edge_vote_wins: got terr_pulses=%0d en=%b abc=%b expected 0 en=1 abc=100",
               terr_seen, en, abc);
    end
    tick(0, 0, 0, 1);
  endtask

  task automatic test_present_hold();
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 1, 0);
      checks++;
      if ({en, abc, vote_ready} !== {1'b1, 3'b010, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got en=%b abc=%b ready=%b expected en=1 abc=010 ready=0",
                 i, en, abc, vote_ready);
      end
    end
    tick(0, 1, 1, 1);
    checks++;
    if (dut_out !== model_out()) begin
      errors++;
      $display("FAIL hold_ack: got %b expected %b", dut_out, model_out());
    end
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL ack_vote_dropped: got en=%b expected en=0", en);
    end
    tick(0, 1, 1, 0);
    checks++;
    if ({en, abc} !== {1'b1, 3'b011}) begin
      errors++;
      $display("FAIL hold_next_frame: got en=%b abc=%b expected en=1 abc=011", en, abc);
    end
    tick(0, 0, 0, 1);
  endtask

  task automatic test_wrap();
    tick(1, 0, 0, 0);
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 3; k++) tick(0, 1, 1'($urandom_range(1)), 0);
      tick(0, 0, 0, 1);
      if (f == 254) begin
        checks++;
        if (frame_cnt !== 8'hFF) begin
          errors++;
          $display("FAIL wrap_all_ones: got %0d expected 255", frame_cnt);
        end
      end
    end
    checks++;
    if (frame_cnt !== 8'h00 || dut_out !== model_out()) begin
      errors++;
      $display("FAIL wrap_zero: got cnt=%0d out=%b expected cnt=0 out=%b",
               frame_cnt, dut_out, model_out());
    end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    checks++;
    if (frame_cnt !== 8'h00 || en !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_ignored: got cnt=%0d en=%b expected cnt=0 en=0", frame_cnt, en);
    end
  endtask

  task automatic test_rst_midframe();
    int terr_seen;
    terr_seen = 0;
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    checks++;
    if (dut_out !== RESET_OUT) begin
      errors++;
      $display("FAIL rst_partial: got %b expected %b", dut_out, RESET_OUT);
    end
    for (int i = 0; i < TIMEOUT + 3; i++) begin
      tick(0, 0, 0, 0);
      terr_seen += int'(timeout_err);
    end
    checks++;
    if (terr_seen != 0) begin
      errors++;
      $display("FAIL rst_no_timeout: got %0d pulses expected 0", terr_seen);
    end
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    tick(1, 0, 0, 0);
    checks++;
    if (dut_out !== RESET_OUT) begin
      errors++;
      $display("FAIL rst_present: got %b expected %b", dut_out, RESET_OUT);
    end
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    checks++;
    if ({en, abc} !== {1'b1, 3'b110}) begin
      errors++;
      $display("FAIL rst_next_frame: got en=%b abc=%b expected en=1 abc=110", en, abc);
    end
    tick(0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(199) == 0,
           $urandom_range(3) != 0 && $urandom_range(9) != 0,
           1'($urandom_range(1)),
           $urandom_range(2) == 0);
      if ($urandom_range(60) == 0) begin
        for (int k = 0; k < TIMEOUT + 2; k++) begin
          tick(0, 0, 1'($urandom_range(1)), $urandom_range(3) == 0);
          checks++;
          if (dut_out !== model_out()) begin
            errors++;
            $display("FAIL random_idle%0d_%0d: got %b expected %b", i, k, dut_out, model_out());
          end
        end
      end
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %b expected %b", i, dut_out, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_timeout();
    test_no_timeout();
    test_present_hold();
    test_wrap();
    test_rst_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
